// File: rtl/lights_pkg.sv
// Shared definitions for the 24-bit light interface.
// Colour field layout, frame FSM states and default LED timing.
package lights_pkg;

    localparam int WORD_W = 24;
    localparam int R_MSB  = 23;
    localparam int G_MSB  = 15;
    localparam int B_MSB  = 7;

    localparam int DEF_T0H  = 2;
    localparam int DEF_T1H  = 5;
    localparam int DEF_TBIT = 8;
    localparam int DEF_TRES = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_e;

    // Put the colour bytes in wire order (G,R,B for WS2812 strips).
    function automatic logic [WORD_W-1:0] reorder(
        input logic [WORD_W-1:0] w,
        input logic              grb
    );
        if (grb)
            return {w[G_MSB -: 8], w[R_MSB -: 8], w[B_MSB -: 8]};
        else
            return w;
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Loadable down-counter shared by the HIGH, LOW and LATCH phases.
// done_o is high while the count sits at zero; a load restarts it.
module led_bit_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins, otherwise count down to zero and park.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/led_serial_tx.sv
// Serialises a 24-bit RGB word onto a WS2812-style single-wire line,
// then holds the line low for the latch gap before taking a new word.
module led_serial_tx
    import lights_pkg::*;
#(
    parameter int T0H       = DEF_T0H,
    parameter int T1H       = DEF_T1H,
    parameter int TBIT      = DEF_TBIT,
    parameter int TRES      = DEF_TRES,
    parameter bit GRB_ORDER = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] light,
    input  logic              valid,
    output logic              ready,
    output logic              dout,
    output logic              busy
);

    localparam int TMAX = (TBIT > TRES) ? TBIT : TRES;
    localparam int CW   = $clog2(TMAX + 1);

    // Phase lengths are loaded as length-1 so a phase of N cycles
    // spends N cycles in its state.
    localparam logic [CW-1:0] L_H0   = CW'(T0H - 1);
    localparam logic [CW-1:0] L_H1   = CW'(T1H - 1);
    localparam logic [CW-1:0] L_L0   = CW'(TBIT - T0H - 1);
    localparam logic [CW-1:0] L_L1   = CW'(TBIT - T1H - 1);
    localparam logic [CW-1:0] L_RES  = CW'(TRES - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [4:0]        bit_q, bit_d;
    logic              ready_q, dout_q, busy_q;

    logic              tmr_load;
    logic [CW-1:0]     tmr_val;
    logic              tmr_done;

    led_bit_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Frame sequencing: accept, per-bit high/low phases, latch gap.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bit_d    = bit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (valid && ready_q) begin
                    sr_d     = reorder(light, GRB_ORDER);
                    bit_d    = 5'd23;
                    state_d  = HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = sr_d[WORD_W-1] ? L_H1 : L_H0;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = sr_q[WORD_W-1] ? L_L1 : L_L0;
                end
            end
            LOW: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_q == 5'd0) begin
                        state_d = LATCH;
                        tmr_val = L_RES;
                    end else begin
                        sr_d    = {sr_q[WORD_W-2:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                        state_d = HIGH;
                        tmr_val = sr_q[WORD_W-2] ? L_H1 : L_H0;
                    end
                end
            end
            LATCH: begin
                if (tmr_done)
                    state_d = IDLE;
            end
        endcase
    end

    // State, data and registered outputs; reset drops any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            ready_q <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            ready_q <= (state_d == IDLE);
            dout_q  <= (state_d == HIGH);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign ready = ready_q;
    assign dout  = dout_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_serial_tx.sv
// Randomised self-checking bench for led_serial_tx.
// Three instances: defaults/GRB, defaults/plain order, short timing.
module tb_led_serial_tx;

    logic        clk;
    logic        rst;
    logic [23:0] light_v [3];
    logic [2:0]  valid_v;
    logic [2:0]  ready_w;
    logic [2:0]  dout_w;
    logic [2:0]  busy_w;

    int T0H_A  [3] = '{2, 2, 1};
    int T1H_A  [3] = '{5, 5, 3};
    int TBIT_A [3] = '{8, 8, 4};
    int TRES_A [3] = '{20, 20, 5};
    int GRB_A  [3] = '{1, 0, 0};

    int n_chk  = 0;
    int n_pass = 0;

    bit          exp_q [$];
    bit          obs_q [$];
    logic [23:0] exp_word;

    led_serial_tx #(
        .T0H(2), .T1H(5), .TBIT(8), .TRES(20), .GRB_ORDER(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .light(light_v[0]), .valid(valid_v[0]),
        .ready(ready_w[0]), .dout(dout_w[0]), .busy(busy_w[0])
    );

    led_serial_tx #(
        .T0H(2), .T1H(5), .TBIT(8), .TRES(20), .GRB_ORDER(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .light(light_v[1]), .valid(valid_v[1]),
        .ready(ready_w[1]), .dout(dout_w[1]), .busy(busy_w[1])
    );

    led_serial_tx #(
        .T0H(1), .T1H(3), .TBIT(4), .TRES(5), .GRB_ORDER(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .light(light_v[2]), .valid(valid_v[2]),
        .ready(ready_w[2]), .dout(dout_w[2]), .busy(busy_w[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: sim time expired, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h at %0t",
                     tag, obs, exp, $time);
    endtask

    // Reference waveform built from the encoding rules directly.
    task automatic build(input int d, input logic [23:0] w);
        logic [23:0] seq;
        int          hi;
        exp_q.delete();
        if (GRB_A[d] != 0)
            seq = {w[15:8], w[23:16], w[7:0]};
        else
            seq = w;
        exp_word = seq;
        for (int i = 23; i >= 0; i--) begin
            hi = seq[i] ? T1H_A[d] : T0H_A[d];
            for (int c = 0; c < TBIT_A[d]; c++)
                exp_q.push_back(c < hi);
        end
        for (int c = 0; c < TRES_A[d]; c++)
            exp_q.push_back(1'b0);
    endtask

    // Called one negedge before the first dout=1 cycle.
    task automatic check_frame(input int d, input logic [23:0] w,
                               input bit drop);
        logic [23:0] rec;
        int          ones;
        build(d, w);
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            obs_q.push_back(dout_w[d]);
            chk($sformatf("dout[%0d] d%0d", k, d), dout_w[d], exp_q[k]);
            chk("busy", busy_w[d], 1);
            chk("ready_low", ready_w[d], 0);
            if (k == 0 && drop)
                valid_v[d] = 1'b0;
        end
        @(negedge clk);
        chk("ready_end", ready_w[d], 1);
        chk("busy_end", busy_w[d], 0);
        chk("dout_end", dout_w[d], 0);
        rec = '0;
        for (int b = 0; b < 24; b++) begin
            ones = 0;
            for (int c = 0; c < TBIT_A[d]; c++)
                ones += int'(obs_q[b * TBIT_A[d] + c]);
            rec[23 - b] = (ones == T1H_A[d]);
        end
        chk("decoded_bits", rec, exp_word);
    endtask

    task automatic send(input int d, input logic [23:0] w,
                        input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        while (ready_w[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("ready_wait", ready_w[d], 1);
            return;
        end
        light_v[d] = w;
        valid_v[d] = 1'b1;
        check_frame(d, w, !hold);
    endtask

    initial begin
        logic [23:0] w2;
        int          d;
        rst        = 1'b1;
        valid_v    = 3'b001;
        light_v[0] = 24'hFF0000;
        light_v[1] = 24'h0;
        light_v[2] = 24'h0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_dout", dout_w, 3'b000);
            chk("rst_busy", busy_w, 3'b000);
            chk("rst_ready", ready_w, 3'b000);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", ready_w, 3'b111);
        chk("rel_busy", busy_w, 3'b000);
        chk("rel_dout", dout_w, 3'b000);
        check_frame(0, 24'hFF0000, 1'b1);

        send(1, 24'hA5C30F, 1'b0);

        w2 = 24'h5A3C96;
        fork
            send(1, 24'hFFFFFF, 1'b1);
            begin
                repeat (100) @(negedge clk);
                light_v[1] = w2;
            end
        join
        check_frame(1, w2, 1'b1);

        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(d, 24'($urandom), 1'b0);
        end

        @(negedge clk);
        light_v[0] = 24'($urandom);
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (13 * 8 + 2) @(negedge clk);
        chk("pre_rst_busy", busy_w[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_dout", dout_w[0], 0);
        chk("abort_busy", busy_w[0], 0);
        chk("abort_ready", ready_w[0], 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready_w[0], 1);
        repeat (3) @(negedge clk);
        chk("no_start_busy", busy_w[0], 0);
        send(0, 24'($urandom), 1'b0);

        send(2, 24'h000001, 1'b0);
        send(2, 24'($urandom), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
